// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags for the OoO dispatcher.
// Optional same-cycle commit bypass on the read ports is enabled by defining REGFILE_BYPASS_EN.
module rename_regfile #(
    parameter int ROB_ID_W = 4,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic [4:0]          dsp_rs1,
    input  logic [4:0]          dsp_rs2,
    output logic                rs1_busy,
    output logic [DATA_W-1:0]   rs1_val,
    output logic [ROB_ID_W-1:0] rs1_tag,
    output logic                rs2_busy,
    output logic [DATA_W-1:0]   rs2_val,
    output logic [ROB_ID_W-1:0] rs2_tag,
    input  logic                dsp_rename_en,
    input  logic [4:0]          dsp_rd,
    input  logic [ROB_ID_W-1:0] dsp_rob_id,
    input  logic                cmt_en,
    input  logic [4:0]          cmt_rd,
    input  logic [ROB_ID_W-1:0] cmt_rob_id,
    input  logic [DATA_W-1:0]   cmt_val
);

    // Storage exists only for x1..x31; x0 is synthesised as constant zero in the views.
    logic [DATA_W-1:0]   val_q [1:31];
    logic [ROB_ID_W-1:0] tag_q [1:31];
    logic [31:1]         busy_q;

    logic [DATA_W-1:0]   val_view [0:31];
    logic [ROB_ID_W-1:0] tag_view [0:31];
    logic [31:0]         busy_view;

    logic [31:0] cmt_wr;
    logic [31:0] cmt_clr;
    logic [31:0] ren_hit;

    always_comb begin
        val_view[0] = '0;
        tag_view[0] = '0;
        for (int r = 1; r < 32; r++) begin
            val_view[r] = val_q[r];
            tag_view[r] = tag_q[r];
        end
        busy_view = {busy_q, 1'b0};
    end

    // One-hot decode of commit and rename targets; bit 0 is always clear so x0 never changes.
    always_comb begin
        cmt_wr  = '0;
        cmt_clr = '0;
        ren_hit = '0;
        for (int r = 1; r < 32; r++) begin
            cmt_wr[r]  = cmt_en && (cmt_rd == 5'(r));
            cmt_clr[r] = cmt_wr[r] && busy_q[r] && (tag_q[r] == cmt_rob_id);
            ren_hit[r] = dsp_rename_en && !flush && (dsp_rd == 5'(r));
        end
    end

    generate
        for (genvar g = 1; g < 32; g++) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    val_q[g]  <= '0;
                    tag_q[g]  <= '0;
                    busy_q[g] <= 1'b0;
                end else if (rdy) begin
                    if (cmt_wr[g]) begin
                        val_q[g] <= cmt_val;
                    end
                    // Flush beats rename; rename beats a matching commit (younger owner wins).
                    if (flush) begin
                        busy_q[g] <= 1'b0;
                    end else if (ren_hit[g]) begin
                        busy_q[g] <= 1'b1;
                        tag_q[g]  <= dsp_rob_id;
                    end else if (cmt_clr[g]) begin
                        busy_q[g] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    // cmt_clr already encodes "commit resolves the current owner", which is exactly the bypass condition.
    function automatic logic bypass_hit(input logic [31:0] clr, input logic [4:0] idx);
        return clr[idx];
    endfunction

    always_comb begin
        rs1_tag = tag_view[dsp_rs1];
        rs2_tag = tag_view[dsp_rs2];
        if (bypass_hit(cmt_clr, dsp_rs1)) begin
            rs1_busy = 1'b0;
            rs1_val  = cmt_val;
        end else begin
            rs1_busy = busy_view[dsp_rs1];
            rs1_val  = val_view[dsp_rs1];
        end
        if (bypass_hit(cmt_clr, dsp_rs2)) begin
            rs2_busy = 1'b0;
            rs2_val  = cmt_val;
        end else begin
            rs2_busy = busy_view[dsp_rs2];
            rs2_val  = val_view[dsp_rs2];
        end
    end
`else
    always_comb begin
        rs1_busy = busy_view[dsp_rs1];
        rs1_val  = val_view[dsp_rs1];
        rs1_tag  = tag_view[dsp_rs1];
        rs2_busy = busy_view[dsp_rs2];
        rs2_val  = val_view[dsp_rs2];
        rs2_tag  = tag_view[dsp_rs2];
    end
`endif

endmodule

// File: tb/tb_rename_regfile.sv
// Directed-vector bench for rename_regfile; expectations follow the build's REGFILE_BYPASS_EN setting.
module tb_rename_regfile;

    localparam int ROB_ID_W = 4;
    localparam int DATA_W   = 32;

    logic                clk = 1'b0;
    logic                rst, rdy, flush;
    logic [4:0]          dsp_rs1, dsp_rs2, dsp_rd, cmt_rd;
    logic                rs1_busy, rs2_busy;
    logic [DATA_W-1:0]   rs1_val, rs2_val, cmt_val;
    logic [ROB_ID_W-1:0] rs1_tag, rs2_tag, dsp_rob_id, cmt_rob_id;
    logic                dsp_rename_en, cmt_en;

    int vectors    = 0;
    int miscompares = 0;

    rename_regfile #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .dsp_rs1(dsp_rs1), .dsp_rs2(dsp_rs2),
        .rs1_busy(rs1_busy), .rs1_val(rs1_val), .rs1_tag(rs1_tag),
        .rs2_busy(rs2_busy), .rs2_val(rs2_val), .rs2_tag(rs2_tag),
        .dsp_rename_en(dsp_rename_en), .dsp_rd(dsp_rd), .dsp_rob_id(dsp_rob_id),
        .cmt_en(cmt_en), .cmt_rd(cmt_rd), .cmt_rob_id(cmt_rob_id), .cmt_val(cmt_val)
    );

    always #5 clk = ~clk;

    // Advance one edge, then clear single-cycle strobes so the next cycle starts idle.
    task automatic step();
        @(posedge clk);
        #1;
        dsp_rename_en = 1'b0;
        cmt_en        = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [3:0] id);
        dsp_rename_en = 1'b1; dsp_rd = rd; dsp_rob_id = id;
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [3:0] id, input logic [31:0] v);
        cmt_en = 1'b1; cmt_rd = rd; cmt_rob_id = id; cmt_val = v;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b0; step(); step(); rst = 1'b0; rdy = 1'b1;
        dsp_rs1 = 5'd5; dsp_rs2 = 5'd31; #1;
        vectors++; if (rs1_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy x5: got %b want 0", rs1_busy); end
        vectors++; if (rs1_val !== 32'h0) begin miscompares++; $display("FAIL reset_val x5: got %h want 0", rs1_val); end
        vectors++; if (rs1_tag !== 4'h0) begin miscompares++; $display("FAIL reset_tag x5: got %h want 0", rs1_tag); end
        vectors++; if (rs2_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy x31: got %b want 0", rs2_busy); end
        do_rename(5'd0, 4'd3); do_commit(5'd0, 4'd3, 32'hFFFF_FFFF); step();
        dsp_rs1 = 5'd0; #1;
        vectors++; if (rs1_busy !== 1'b0) begin miscompares++; $display("FAIL x0_busy: got %b want 0", rs1_busy); end
        vectors++; if (rs1_val !== 32'h0) begin miscompares++; $display("FAIL x0_val: got %h want 0", rs1_val); end
        vectors++; if (rs1_tag !== 4'h0) begin miscompares++; $display("FAIL x0_tag: got %h want 0", rs1_tag); end
    endtask

    task automatic test_rename_commit();
        dsp_rs1 = 5'd5; dsp_rs2 = 5'd5;
        do_rename(5'd5, 4'd7); #1;
        vectors++; if (rs1_busy !== 1'b0) begin miscompares++; $display("FAIL same_cycle_read_old: got busy %b want 0", rs1_busy); end
        step();
        vectors++; if (rs1_busy !== 1'b1) begin miscompares++; $display("FAIL rename_busy: got %b want 1", rs1_busy); end
        vectors++; if (rs1_tag !== 4'd7) begin miscompares++; $display("FAIL rename_tag: got %0d want 7", rs1_tag); end
        vectors++; if (rs2_tag !== 4'd7) begin miscompares++; $display("FAIL rename_tag_rs2: got %0d want 7", rs2_tag); end
        do_commit(5'd5, 4'd7, 32'hDEAD_BEEF); step();
        vectors++; if (rs1_busy !== 1'b0) begin miscompares++; $display("FAIL commit_busy: got %b want 0", rs1_busy); end
        vectors++; if (rs1_val !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL commit_val: got %h want deadbeef", rs1_val); end
        vectors++; if (rs2_val !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL commit_val_rs2: got %h want deadbeef", rs2_val); end
    endtask

    task automatic test_stale_commit();
        dsp_rs1 = 5'd5;
        do_rename(5'd5, 4'd2); step();
        do_rename(5'd5, 4'd9); step();
        do_commit(5'd5, 4'd2, 32'h11); step();
        vectors++; if (rs1_val !== 32'h11) begin miscompares++; $display("FAIL stale_val: got %h want 11", rs1_val); end
        vectors++; if (rs1_busy !== 1'b1) begin miscompares++; $display("FAIL stale_busy: got %b want 1", rs1_busy); end
        vectors++; if (rs1_tag !== 4'd9) begin miscompares++; $display("FAIL stale_tag: got %0d want 9", rs1_tag); end
    endtask

    task automatic test_same_cycle();
        dsp_rs2 = 5'd6;
        do_rename(5'd6, 4'd4); step();
        do_commit(5'd6, 4'd4, 32'h22); do_rename(5'd6, 4'd5); step();
        vectors++; if (rs2_val !== 32'h22) begin miscompares++; $display("FAIL same_val: got %h want 22", rs2_val); end
        vectors++; if (rs2_busy !== 1'b1) begin miscompares++; $display("FAIL same_busy: got %b want 1", rs2_busy); end
        vectors++; if (rs2_tag !== 4'd5) begin miscompares++; $display("FAIL same_tag: got %0d want 5", rs2_tag); end
    endtask

    task automatic test_flush_pause();
        do_rename(5'd1, 4'd1); step();
        do_rename(5'd2, 4'd2); step();
        flush = 1'b1; do_commit(5'd3, 4'd0, 32'h33); do_rename(5'd4, 4'd8); step();
        dsp_rs1 = 5'd1; dsp_rs2 = 5'd2; #1;
        vectors++; if (rs1_busy !== 1'b0) begin miscompares++; $display("FAIL flush_x1: got %b want 0", rs1_busy); end
        vectors++; if (rs2_busy !== 1'b0) begin miscompares++; $display("FAIL flush_x2: got %b want 0", rs2_busy); end
        dsp_rs1 = 5'd4; dsp_rs2 = 5'd3; #1;
        vectors++; if (rs1_busy !== 1'b0) begin miscompares++; $display("FAIL flush_drop_rename: got %b want 0", rs1_busy); end
        vectors++; if (rs2_val !== 32'h33) begin miscompares++; $display("FAIL flush_commit_val: got %h want 33", rs2_val); end
        vectors++; if (dut.busy_q[6] !== 1'b0) begin miscompares++; $display("FAIL flush_x6: got %b want 0", dut.busy_q[6]); end
        rdy = 1'b0; dsp_rs1 = 5'd7;
        do_rename(5'd7, 4'd3); do_commit(5'd7, 4'd0, 32'h77); step();
        rdy = 1'b1; #1;
        vectors++; if (rs1_busy !== 1'b0) begin miscompares++; $display("FAIL pause_busy: got %b want 0", rs1_busy); end
        vectors++; if (rs1_val !== 32'h0) begin miscompares++; $display("FAIL pause_val: got %h want 0", rs1_val); end
    endtask

    task automatic test_bypass();
        dsp_rs1 = 5'd8;
        do_rename(5'd8, 4'd6); step();
        do_commit(5'd8, 4'd6, 32'h44); #1;
`ifdef REGFILE_BYPASS_EN
        vectors++; if (rs1_busy !== 1'b0) begin miscompares++; $display("FAIL bypass_busy: got %b want 0", rs1_busy); end
        vectors++; if (rs1_val !== 32'h44) begin miscompares++; $display("FAIL bypass_val: got %h want 44", rs1_val); end
`else
        vectors++; if (rs1_busy !== 1'b1) begin miscompares++; $display("FAIL nobypass_busy: got %b want 1", rs1_busy); end
        vectors++; if (rs1_tag !== 4'd6) begin miscompares++; $display("FAIL nobypass_tag: got %0d want 6", rs1_tag); end
`endif
        step();
        vectors++; if (rs1_busy !== 1'b0) begin miscompares++; $display("FAIL post_commit_busy: got %b want 0", rs1_busy); end
        vectors++; if (rs1_val !== 32'h44) begin miscompares++; $display("FAIL post_commit_val: got %h want 44", rs1_val); end
    endtask

    task automatic test_mid_reset();
        do_rename(5'd9, 4'd12); step();
        do_commit(5'd10, 4'd0, 32'hA5A5_0001); step();
        rst = 1'b1; do_rename(5'd11, 4'd1); step(); rst = 1'b0;
        dsp_rs1 = 5'd9; dsp_rs2 = 5'd10; #1;
        vectors++; if (rs1_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", rs1_busy); end
        vectors++; if (rs1_tag !== 4'd0) begin miscompares++; $display("FAIL midrst_tag: got %0d want 0", rs1_tag); end
        vectors++; if (rs2_val !== 32'h0) begin miscompares++; $display("FAIL midrst_val: got %h want 0", rs2_val); end
        dsp_rs1 = 5'd11; dsp_rs2 = 5'd5; #1;
        vectors++; if (rs1_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_rename: got %b want 0", rs1_busy); end
        vectors++; if (rs2_val !== 32'h0) begin miscompares++; $display("FAIL midrst_x5: got %h want 0", rs2_val); end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        dsp_rs1 = '0; dsp_rs2 = '0; dsp_rd = '0; dsp_rob_id = '0;
        dsp_rename_en = 1'b0; cmt_en = 1'b0; cmt_rd = '0; cmt_rob_id = '0; cmt_val = '0;
        test_reset();
        test_rename_commit();
        test_stale_commit();
        test_same_cycle();
        test_flush_pause();
        test_bypass();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
